wb_trace_fifo: RTL and testbench

Downstream consumer of the CPU core's writeback debug outputs (debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata) in the SoC top.
- Captures every architecturally visible register-file write.
- Buffers captured writes in a synchronous FIFO.
- Presents them on a valid/ready stream to a trace sink: testbench golden-trace comparator or UART dumper.
- Counts entries lost to overflow, so comparison never silently skips a write.

---
 rtl/wb_trace_fifo_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/wb_trace_fifo.sv | 116 +++++++++++
 tb/tb_wb_trace_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_fifo_pkg.sv
// Shared trace-entry definitions: field widths, packing offsets and the capture qualifier.
// Entry layout (LSB first): wdata, wnum, pc and, when TRACE_CYCLE_STAMP_EN is defined, stamp.
package wb_trace_fifo_pkg;

    localparam int unsigned TR_PC_W    = 32;
    localparam int unsigned TR_WNUM_W  = 5;
    localparam int unsigned TR_DATA_W  = 32;
    localparam int unsigned TR_STAMP_W = 32;

    localparam int unsigned TR_WDATA_LSB = 0;
    localparam int unsigned TR_WNUM_LSB  = TR_WDATA_LSB + TR_DATA_W;
    localparam int unsigned TR_PC_LSB    = TR_WNUM_LSB + TR_WNUM_W;
    localparam int unsigned TR_STAMP_LSB = TR_PC_LSB + TR_PC_W;

`ifdef TRACE_CYCLE_STAMP_EN
    localparam int unsigned TR_ENTRY_W = TR_STAMP_LSB + TR_STAMP_W;
`else
    localparam int unsigned TR_ENTRY_W = TR_STAMP_LSB;
`endif

    // A writeback is architecturally visible only if some byte is written to a register other than $0.
    function automatic logic wb_is_capture(input logic       en,
                                           input logic [3:0] wen,
                                           input logic [4:0] wnum);
        return en && (wen != 4'b0000) && (wnum != 5'd0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational (first-word-fall-through) read of the head entry.
// Caller guarantees push is never asserted when full without a same-cycle pop, and pop never when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Storage write; contents need no reset since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy next-state; pointers wrap modulo DEPTH by width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_trace_fifo.sv
// Writeback trace capture: qualifies register-file writes from the core, buffers them in a
// FWFT FIFO, streams them out on valid/ready and counts captures lost to overflow.
// Optional macro TRACE_CYCLE_STAMP_EN adds a free-running cycle stamp to each entry.
module wb_trace_fifo
    import wb_trace_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   trace_en,
    input  logic [31:0]            debug_wb_pc,
    input  logic [3:0]             debug_wb_rf_wen,
    input  logic [4:0]             debug_wb_rf_wnum,
    input  logic [31:0]            debug_wb_rf_wdata,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [31:0]            trace_pc,
    output logic [4:0]             trace_wnum,
    output logic [31:0]            trace_wdata,
    output logic [31:0]            trace_stamp,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt,
    input  logic                   clr_overflow
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic                  cap, pop, push, drop, full;
    logic [TR_ENTRY_W-1:0] entry_in, entry_out, head;
    logic                  overflow_q, overflow_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

    assign cap  = wb_is_capture(trace_en, debug_wb_rf_wen, debug_wb_rf_wnum);
    assign full = (fifo_count == CntW'(DEPTH));
    assign pop  = trace_valid && trace_ready;
    // Full with a same-cycle pop still accepts the new entry.
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [TR_STAMP_W-1:0] stamp_q;

    // Free-running cycle counter sampled into each captured entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stamp_q <= '0;
        else         stamp_q <= stamp_q + TR_STAMP_W'(1);
    end
`endif

    // Pack the writeback fields into one FIFO word.
    always_comb begin
        entry_in = '0;
        entry_in[TR_WDATA_LSB +: TR_DATA_W] = debug_wb_rf_wdata;
        entry_in[TR_WNUM_LSB  +: TR_WNUM_W] = debug_wb_rf_wnum;
        entry_in[TR_PC_LSB    +: TR_PC_W]   = debug_wb_pc;
`ifdef TRACE_CYCLE_STAMP_EN
        entry_in[TR_STAMP_LSB +: TR_STAMP_W] = stamp_q;
`endif
    end

    sync_fifo #(
        .WIDTH (TR_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (entry_in),
        .dout   (entry_out),
        .count  (fifo_count)
    );

    assign trace_valid = (fifo_count != '0);
    // Storage is not reset, so present zeros while empty.
    assign head        = trace_valid ? entry_out : '0;
    assign trace_wdata = head[TR_WDATA_LSB +: TR_DATA_W];
    assign trace_wnum  = head[TR_WNUM_LSB  +: TR_WNUM_W];
    assign trace_pc    = head[TR_PC_LSB    +: TR_PC_W];
`ifdef TRACE_CYCLE_STAMP_EN
    assign trace_stamp = head[TR_STAMP_LSB +: TR_STAMP_W];
`else
    assign trace_stamp = {TR_STAMP_W{1'b0}};
`endif

    // Overflow bookkeeping; clear takes priority over a same-cycle drop.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Overflow state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed self-checking bench for wb_trace_fifo (DEPTH=8, CNT_W=16).
// Honours TRACE_CYCLE_STAMP_EN when defined for the build.
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        resetn;
    logic        trace_en;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
    logic [31:0] trace_stamp;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wb_trace_fifo #(
        .DEPTH (8),
        .CNT_W (16)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .trace_en          (trace_en),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_pc          (trace_pc),
        .trace_wnum        (trace_wnum),
        .trace_wdata       (trace_wdata),
        .trace_stamp       (trace_stamp),
        .fifo_count        (fifo_count),
        .overflow          (overflow),
        .drop_cnt          (drop_cnt),
        .clr_overflow      (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wb(input logic en, input logic [3:0] wen, input logic [4:0] wnum,
                      input logic [31:0] pc, input logic [31:0] data);
        trace_en          = en;
        debug_wb_rf_wen   = wen;
        debug_wb_rf_wnum  = wnum;
        debug_wb_pc       = pc;
        debug_wb_rf_wdata = data;
    endtask

    task automatic idle();
        wb(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] exp_stamp(input int n);
`ifdef TRACE_CYCLE_STAMP_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got 0 want 1");
        $fatal(1);
    end

    initial begin
        int  sent, got, mcnt;
        logic do_cap, do_pop;
        logic [31:0] exp_pc;

        // Reset held with an active capture on the inputs.
        resetn       = 1'b0;
        trace_ready  = 1'b0;
        clr_overflow = 1'b0;
        wb(1'b1, 4'hF, 5'd3, 32'hDEAD0000, 32'h11111111);
        tick(); tick(); tick();
        check_val("rst_valid", trace_valid, 1'b0);
        check_val("rst_count", fifo_count, 4'd0);
        check_val("rst_drop", drop_cnt, 16'd0);
        check_val("rst_ovf", overflow, 1'b0);
        check_val("rst_pc", trace_pc, 32'h0);
        idle();
        resetn = 1'b1;
        cyc    = 0;

        // First capture at cycle 10, second at cycle 13; latency is one cycle.
        while (cyc < 10) tick();
        wb(1'b1, 4'hF, 5'd3, 32'hBFC00100, 32'hA5A5A5A5);
        check_val("lat_pre_valid", trace_valid, 1'b0);
        tick();
        idle();
        check_val("lat_valid", trace_valid, 1'b1);
        check_val("lat_pc", trace_pc, 32'hBFC00100);
        check_val("lat_stamp0", trace_stamp, exp_stamp(10));
        check_val("lat_count", fifo_count, 4'd1);
        while (cyc < 13) tick();
        wb(1'b1, 4'hF, 5'd4, 32'hBFC00104, 32'h5A5A5A5A);
        tick();
        idle();
        check_val("stamp_count", fifo_count, 4'd2);
        check_val("hold_pc", trace_pc, 32'hBFC00100);
        trace_ready = 1'b1;
        tick();
        check_val("stamp_pc1", trace_pc, 32'hBFC00104);
        check_val("stamp_wdata1", trace_wdata, 32'h5A5A5A5A);
        check_val("lat_stamp1", trace_stamp, exp_stamp(13));
        tick();
        trace_ready = 1'b0;
        check_val("stamp_empty", trace_valid, 1'b0);

        // Filtering: $0, no enables, capture disabled.
        wb(1'b1, 4'hF, 5'd0, 32'h1000, 32'h1);
        tick();
        wb(1'b1, 4'h0, 5'd5, 32'h1004, 32'h2);
        tick();
        wb(1'b0, 4'h3, 5'd5, 32'h1008, 32'h3);
        tick();
        check_val("filt_count0", fifo_count, 4'd0);
        check_val("filt_valid0", trace_valid, 1'b0);
        wb(1'b1, 4'h1, 5'd5, 32'hBFC00010, 32'h12345678);
        tick();
        idle();
        check_val("filt_count1", fifo_count, 4'd1);
        check_val("filt_pc", trace_pc, 32'hBFC00010);
        check_val("filt_wnum", trace_wnum, 5'd5);
        check_val("filt_wdata", trace_wdata, 32'h12345678);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        check_val("filt_drained", fifo_count, 4'd0);

        // Ordering with random back-pressure, paced to avoid overflow; wraps pointers twice.
        sent = 0;
        got  = 0;
        mcnt = 0;
        for (int c = 0; c < 400 && got < 20; c++) begin
            trace_ready = 1'($urandom_range(0, 1));
            do_cap = (sent < 20) && (mcnt < 8);
            if (do_cap) wb(1'b1, 4'hF, 5'd7, 32'hBFC00000 + 32'(4 * sent), 32'(sent));
            else        idle();
            check_val("ord_valid", trace_valid, mcnt != 0);
            do_pop = trace_ready && (mcnt != 0);
            if (do_pop) begin
                check_val("ord_pc", trace_pc, 32'hBFC00000 + 32'(4 * got));
                got++;
            end
            tick();
            if (do_cap) sent++;
            mcnt = mcnt + int'(do_cap) - int'(do_pop);
        end
        idle();
        trace_ready = 1'b0;
        check_val("ord_got", 64'(got), 64'd20);
        check_val("ord_empty", fifo_count, 4'd0);
        check_val("ord_nodrop", drop_cnt, 16'd0);

        // Overflow: 11 captures into a stalled FIFO drops 3.
        for (int i = 0; i < 11; i++) begin
            wb(1'b1, 4'hF, 5'd9, 32'h100 + 32'(4 * i), 32'(i));
            tick();
        end
        idle();
        check_val("ovf_count", fifo_count, 4'd8);
        check_val("ovf_flag", overflow, 1'b1);
        check_val("ovf_drop", drop_cnt, 16'd3);
        // Clear coincides with another drop; clear wins.
        clr_overflow = 1'b1;
        wb(1'b1, 4'hF, 5'd9, 32'h999, 32'h0);
        tick();
        clr_overflow = 1'b0;
        idle();
        check_val("clr_drop", drop_cnt, 16'd0);
        check_val("clr_flag", overflow, 1'b0);
        check_val("clr_count", fifo_count, 4'd8);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val("ovf_drain_pc", trace_pc, 32'h100 + 32'(4 * i));
            tick();
        end
        trace_ready = 1'b0;
        check_val("ovf_drained", trace_valid, 1'b0);

        // Full with simultaneous push and pop for 5 cycles.
        for (int i = 0; i < 8; i++) begin
            wb(1'b1, 4'hF, 5'd10, 32'h200 + 32'(4 * i), 32'(i));
            tick();
        end
        check_val("full_count", fifo_count, 4'd8);
        trace_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wb(1'b1, 4'hF, 5'd10, 32'h300 + 32'(4 * j), 32'(j));
            check_val("full_pop_pc", trace_pc, 32'h200 + 32'(4 * j));
            tick();
            check_val("full_hold_count", fifo_count, 4'd8);
        end
        idle();
        check_val("full_drop", drop_cnt, 16'd0);
        check_val("full_ovf", overflow, 1'b0);
        for (int k = 0; k < 8; k++) begin
            exp_pc = (k < 3) ? 32'h214 + 32'(4 * k) : 32'h300 + 32'(4 * (k - 3));
            check_val("full_drain_pc", trace_pc, exp_pc);
            tick();
        end
        trace_ready = 1'b0;
        check_val("full_empty_valid", trace_valid, 1'b0);
        check_val("full_empty_count", fifo_count, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
